// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-wide carry per stage, so the latency is STAGES cycles.
// The whole pipe stalls while the output beat is held; In_ready = Out_ready || !Out_valid.
module pipelined_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 4
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  In_valid,
  output logic                  In_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Carry_in,
  input  logic                  Sub,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [DATA_WIDTH-1:0] Sum,
  output logic                  Carry_out,
  output logic                  Overflow
);
  localparam int CHUNK = DATA_WIDTH / STAGES;

  logic                  w_adv;
  logic                  w_c_eff;
  logic [DATA_WIDTH-1:0] w_b_eff;
  logic                  w_a_msb;
  logic                  w_b_msb;
  logic                  w_s_msb;
  logic                  r_ovf;

  assign w_adv    = Out_ready || !Out_valid;
  assign In_ready = w_adv;
  // Subtract is A + ~B + ~borrow, so both inversions happen once, at capture.
  assign w_b_eff  = Sub ? ~B : B;
  assign w_c_eff  = Carry_in ^ Sub;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      localparam int IN_W = DATA_WIDTH - k * CHUNK;
      localparam int SW   = (k + 1) * CHUNK;

      logic             w_vld_src;
      logic             w_cy_src;
      logic [IN_W-1:0]  w_a_src;
      logic [IN_W-1:0]  w_b_src;
      logic [CHUNK:0]   w_part;
      logic [SW-1:0]    w_sum_nxt;
      logic             r_vld;
      logic             r_cy;
      logic [SW-1:0]    r_sum;

      if (k == 0) begin : g_first
        assign w_vld_src = In_valid;
        assign w_cy_src  = w_c_eff;
        assign w_a_src   = A;
        assign w_b_src   = w_b_eff;
        assign w_sum_nxt = w_part[CHUNK-1:0];
      end else begin : g_chain
        assign w_vld_src = g_stage[k-1].r_vld;
        assign w_cy_src  = g_stage[k-1].r_cy;
        assign w_a_src   = g_stage[k-1].g_ops.r_a;
        assign w_b_src   = g_stage[k-1].g_ops.r_b;
        assign w_sum_nxt = {w_part[CHUNK-1:0], g_stage[k-1].r_sum};
      end

      // The lowest chunk of the remaining operands is always the one resolved here.
      assign w_part = {1'b0, w_a_src[CHUNK-1:0]} + {1'b0, w_b_src[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, w_cy_src};

      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          r_vld <= 1'b0;
          r_cy  <= 1'b0;
          r_sum <= '0;
        end else if (w_adv) begin
          r_vld <= w_vld_src;
          r_cy  <= w_part[CHUNK];
          r_sum <= w_sum_nxt;
        end
      end

      if (k < STAGES - 1) begin : g_ops
        logic [IN_W-CHUNK-1:0] r_a;
        logic [IN_W-CHUNK-1:0] r_b;

        always_ff @(posedge CLK or negedge RST_n) begin
          if (!RST_n) begin
            r_a <= '0;
            r_b <= '0;
          end else if (w_adv) begin
            r_a <= w_a_src[IN_W-1:CHUNK];
            r_b <= w_b_src[IN_W-1:CHUNK];
          end
        end
      end
    end
  endgenerate

  // The last stage still sees the top chunk of A and B', so the sign bits come for free.
  assign w_a_msb = g_stage[STAGES-1].w_a_src[CHUNK-1];
  assign w_b_msb = g_stage[STAGES-1].w_b_src[CHUNK-1];
  assign w_s_msb = g_stage[STAGES-1].w_part[CHUNK-1];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= (w_a_msb == w_b_msb) && (w_s_msb != w_a_msb);
    end
  end

  assign Out_valid = g_stage[STAGES-1].r_vld;
  assign Sum       = g_stage[STAGES-1].r_sum;
  assign Carry_out = g_stage[STAGES-1].r_cy;
  assign Overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four configurations (8/2, 32/4, 64/8, 8/1) checked against
// an arithmetic reference model plus directed literal expectations.
module tb_pipelined_adder;
  localparam int N = 4;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        iv  [N];
  logic        ord [N];
  logic        ci  [N];
  logic        sb  [N];
  logic [63:0] a   [N];
  logic [63:0] b   [N];
  logic        ir  [N];
  logic        ov  [N];
  logic        co  [N];
  logic        of  [N];
  logic [7:0]  s0;
  logic [31:0] s1;
  logic [63:0] s2;
  logic [7:0]  s3;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [65:0] exp_q [N][16];
  int          wr   [N];
  int          rd   [N];
  int          nout [N];

  always #5 CLK = ~CLK;

  pipelined_adder #(.DATA_WIDTH(8), .STAGES(2)) u0 (
    .CLK(CLK), .RST_n(RST_n), .In_valid(iv[0]), .In_ready(ir[0]), .A(a[0][7:0]), .B(b[0][7:0]),
    .Carry_in(ci[0]), .Sub(sb[0]), .Out_valid(ov[0]), .Out_ready(ord[0]), .Sum(s0),
    .Carry_out(co[0]), .Overflow(of[0]));
  pipelined_adder #(.DATA_WIDTH(32), .STAGES(4)) u1 (
    .CLK(CLK), .RST_n(RST_n), .In_valid(iv[1]), .In_ready(ir[1]), .A(a[1][31:0]), .B(b[1][31:0]),
    .Carry_in(ci[1]), .Sub(sb[1]), .Out_valid(ov[1]), .Out_ready(ord[1]), .Sum(s1),
    .Carry_out(co[1]), .Overflow(of[1]));
  pipelined_adder #(.DATA_WIDTH(64), .STAGES(8)) u2 (
    .CLK(CLK), .RST_n(RST_n), .In_valid(iv[2]), .In_ready(ir[2]), .A(a[2]), .B(b[2]),
    .Carry_in(ci[2]), .Sub(sb[2]), .Out_valid(ov[2]), .Out_ready(ord[2]), .Sum(s2),
    .Carry_out(co[2]), .Overflow(of[2]));
  pipelined_adder #(.DATA_WIDTH(8), .STAGES(1)) u3 (
    .CLK(CLK), .RST_n(RST_n), .In_valid(iv[3]), .In_ready(ir[3]), .A(a[3][7:0]), .B(b[3][7:0]),
    .Carry_in(ci[3]), .Sub(sb[3]), .Out_valid(ov[3]), .Out_ready(ord[3]), .Sum(s3),
    .Carry_out(co[3]), .Overflow(of[3]));

  function automatic int dw_of(input int i);
    case (i)
      0: return 8;
      1: return 32;
      2: return 64;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] sum_of(input int i);
    case (i)
      0: return {56'b0, s0};
      1: return {32'b0, s1};
      2: return s2;
      default: return {56'b0, s3};
    endcase
  endfunction

  function automatic logic [65:0] res(input int i);
    return {co[i], of[i], sum_of(i)};
  endfunction

  // Reference: exact integer arithmetic, unsigned for carry/borrow, signed range for overflow.
  function automatic logic [65:0] model(input logic [63:0] a_in, input logic [63:0] b_in,
                                        input logic c, input logic s, input int dw);
    logic [65:0]        mask, ua, ub, uc, ur;
    logic signed [65:0] sa, sbv, sr, lim;
    logic               co_m, ov_m;
    mask = (66'd1 << dw) - 66'd1;
    ua   = {2'b0, a_in} & mask;
    ub   = {2'b0, b_in} & mask;
    uc   = {65'b0, c};
    if (s) begin
      ur   = ua - ub - uc;
      co_m = (ua >= ub + uc);
    end else begin
      ur   = ua + ub + uc;
      co_m = ((ur >> dw) != 66'd0);
    end
    lim = 66'sd1 <<< (dw - 1);
    sa  = $signed(ua);
    sbv = $signed(ub);
    if (((ua >> (dw - 1)) & 66'd1) != 66'd0) sa = sa - (66'sd1 <<< dw);
    if (((ub >> (dw - 1)) & 66'd1) != 66'd0) sbv = sbv - (66'sd1 <<< dw);
    sr   = s ? (sa - sbv - $signed(uc)) : (sa + sbv + $signed(uc));
    ov_m = (sr >= lim) || (sr < -lim);
    return {co_m, ov_m, ur[63:0] & mask[63:0]};
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Scoreboard step, run once per cycle away from the rising edge.
  task automatic sample();
    for (int i = 0; i < N; i++) begin
      if (!RST_n) begin
        wr[i] = 0;
        rd[i] = 0;
      end else begin
        if (ov[i] && ord[i]) begin
          if (wr[i] == rd[i]) begin
            n_chk++;
            $display("FAIL sb%0d spurious: Out_valid=1 with nothing pending, expected 0", i);
          end else begin
            chk($sformatf("sb%0d result", i), res(i), exp_q[i][rd[i] % 16]);
            rd[i]++;
          end
          nout[i]++;
        end
        if (iv[i] && ir[i]) begin
          exp_q[i][wr[i] % 16] = model(a[i], b[i], ci[i], sb[i], dw_of(i));
          wr[i]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    sample();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int i, input logic [63:0] av, input logic [63:0] bv,
                       input logic c, input logic s);
    iv[i] = 1'b1;
    a[i]  = av;
    b[i]  = bv;
    ci[i] = c;
    sb[i] = s;
  endtask

  initial begin
    int n0;
    RST_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      iv[i] = 1'b0; ord[i] = 1'b1; ci[i] = 1'b0; sb[i] = 1'b0;
      a[i] = '0; b[i] = '0; wr[i] = 0; rd[i] = 0; nout[i] = 0;
    end

    chk("model add 8b", model(64'hFF, 64'h01, 1'b0, 1'b0, 8), {2'b10, 64'h00});
    chk("model sub 8b ovf", model(64'h80, 64'h01, 1'b0, 1'b1, 8), {2'b11, 64'h7F});
    chk("model sub 8b borrow", model(64'h00, 64'h01, 1'b0, 1'b1, 8), {2'b00, 64'hFF});
    chk("model add 32b ovf", model(64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 32), {2'b01, 64'h8000_0000});
    chk("model sub 64b borrow-in", model(64'h0, 64'h0, 1'b1, 1'b1, 64), {2'b00, 64'hFFFF_FFFF_FFFF_FFFF});
    chk("model sub borrow-in", model(64'h5, 64'h3, 1'b1, 1'b1, 8), {2'b10, 64'h01});

    #1 RST_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset valid %0d", i), 66'(ov[i]), 66'd0);
      chk($sformatf("reset outputs %0d", i), res(i), 66'd0);
      chk($sformatf("reset in_ready %0d", i), 66'(ir[i]), 66'd1);
    end
    tick();
    tick();
    RST_n = 1'b1;
    tick();

    drive(0, 64'hFF, 64'h01, 1'b0, 1'b0); tick();
    chk("8b latency not 1", 66'(ov[0]), 66'd0);
    drive(0, 64'h80, 64'h01, 1'b0, 1'b1); tick();
    chk("8b add valid", 66'(ov[0]), 66'd1);
    chk("8b add result", res(0), {2'b10, 64'h00});
    drive(0, 64'h00, 64'h01, 1'b0, 1'b1); tick();
    chk("8b sub ovf result", res(0), {2'b11, 64'h7F});
    iv[0] = 1'b0; tick();
    chk("8b sub borrow result", res(0), {2'b00, 64'hFF});
    tick();
    chk("8b drained", 66'(ov[0]), 66'd0);

    for (int j = 0; j < 11; j++) begin
      if (j < 8) drive(1, 64'(j), 64'hFFFF_FFFF, 1'b1, 1'b0);
      else iv[1] = 1'b0;
      tick();
      if (j >= 3) begin
        chk($sformatf("stream valid %0d", j), 66'(ov[1]), 66'd1);
        chk($sformatf("stream result %0d", j), res(1), {2'b10, 64'(j - 3)});
      end else begin
        chk($sformatf("stream early %0d", j), 66'(ov[1]), 66'd0);
      end
    end
    tick();
    chk("stream drained", 66'(ov[1]), 66'd0);

    n0 = nout[1];
    for (int k = 0; k < 4; k++) begin
      drive(1, 64'h1000_0000 * 64'(k + 1), 64'h0F0F_0F0F, 1'(k), 1'(k));
      tick();
    end
    iv[1]  = 1'b0;
    ord[1] = 1'b0;
    #1;
    chk("stall in_ready", 66'(ir[1]), 66'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall valid %0d", k), 66'(ov[1]), 66'd1);
      chk($sformatf("stall hold %0d", k), res(1), {2'b00, 64'h1F0F_0F0F});
      chk($sformatf("stall in_ready %0d", k), 66'(ir[1]), 66'd0);
    end
    ord[1] = 1'b1;
    repeat (6) tick();
    chk("stall beat count", 66'(nout[1] - n0), 66'd4);
    chk("stall queue empty", 66'(wr[1] - rd[1]), 66'd0);

    drive(1, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0); tick();
    for (int k = 1; k < 4; k++) begin
      drive(1, 64'(k), 64'(k), 1'b0, 1'b0);
      tick();
    end
    iv[1] = 1'b0;
    chk("pre-reset result", res(1), {2'b01, 64'h8000_0000});
    #2 RST_n = 1'b0;
    #1;
    chk("mid reset valid", 66'(ov[1]), 66'd0);
    chk("mid reset outputs", res(1), 66'd0);
    chk("mid reset in_ready", 66'(ir[1]), 66'd1);
    tick();
    tick();
    RST_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post reset idle %0d", k), 66'(ov[1]), 66'd0);
    end
    drive(1, 64'h5, 64'h3, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      iv[1] = 1'b0;
      chk($sformatf("post reset latency %0d", k), 66'(ov[1]), 66'(k == 3));
    end
    chk("post reset result", res(1), {2'b10, 64'h2});
    tick();

    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        iv[i]  = ($urandom_range(0, 3) != 0);
        ord[i] = ($urandom_range(0, 3) != 0);
        a[i]   = {$urandom, $urandom};
        b[i]   = {$urandom, $urandom};
        ci[i]  = 1'($urandom_range(0, 1));
        sb[i]  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      iv[i]  = 1'b0;
      ord[i] = 1'b1;
    end
    repeat (12) tick();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("random drain %0d", i), 66'(wr[i] - rd[i]), 66'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit for wide operands.
- Splits DATA_WIDTH into STAGES equal chunks and resolves one chunk's carry per clock. This trades latency for a short carry chain.
- Valid/ready handshakes on input and output, with full back-pressure, so it drops into streaming datapaths.
- Provides signed-overflow and carry/borrow flags.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; must satisfy 1 <= STAGES <= DATA_WIDTH. CHUNK = DATA_WIDTH/STAGES.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_n  input  1  asynchronous, active-low reset.
- In_valid  input  1  operand beat valid.
- In_ready  output  1  unit can accept a beat this cycle.
- A  input  DATA_WIDTH  operand A (unsigned or two's complement).
- B  input  DATA_WIDTH  operand B.
- Carry_in  input  1  carry-in (add) / borrow-in (sub).
- Sub  input  1  0: add, 1: subtract.
- Out_valid  output  1  result beat valid.
- Out_ready  input  1  downstream accepts the result.
- Sum  output  DATA_WIDTH  result.
- Carry_out  output  1  carry-out (add) / NOT borrow-out (sub).
- Overflow  output  1  signed two's-complement overflow.

Behaviour:
- Arithmetic:
  - Sub=0: {Carry_out,Sum} = A + B + Carry_in.
  - Sub=1: {Carry_out,Sum} = A + ~B + ~Carry_in, i.e. Sum = A - B - Carry_in mod 2^DATA_WIDTH. Carry_out=1 means no borrow.
  - Overflow = (A[MSB] == B'[MSB]) && (Sum[MSB] != A[MSB]), where B' = B (add) or ~B (sub).
- Operand capture:
  - A, B, Carry_in and Sub are sampled only on an accepted beat, i.e. a cycle where In_valid && In_ready.
  - B is inverted and the effective carry is formed at capture.
- Pipeline:
  - Stage k (k = 1..STAGES) holds a valid bit, result chunks 0..k-1, carry out of chunk k-1, the unprocessed upper chunks of A and B', and A[MSB]/B'[MSB] for the overflow calculation.
  - Stage 1 computes chunk 0 from the input. Stage k+1 computes chunk k using stage k's carry.
  - The output registers are stage STAGES. Sum, Carry_out, Overflow and Out_valid are driven directly from flops, with no combinational path from A/B.
- Flow control:
  - advance = Out_ready || !Out_valid. When advance=1, every stage shifts forward one position.
  - In_ready = advance. This is combinational from Out_ready and the registered Out_valid.
  - When advance=0, all stages hold. Sum, Carry_out and Overflow stay stable while Out_valid=1 && Out_ready=0.
  - Stage valid bits propagate; a bubble (In_valid=0 on an advance cycle) enters as valid=0.
  - Throughput is one beat per cycle with Out_ready held high; there is no bubble between back-to-back beats.
- Latency:
  - A beat accepted at cycle t presents Out_valid=1 at cycle t+STAGES if there is no stall.
  - Stall cycles add 1:1 to the latency.
- STAGES=1: the unit reduces to a single registered adder with latency 1.
- Reset:
  - RST_n low clears all valid bits and output registers immediately, independent of CLK.
  - Reset values: Out_valid=0, Sum=0, Carry_out=0, Overflow=0. In_ready=1 while in reset, since Out_valid=0.
  - Reset mid-operation discards all in-flight beats; no partial result is emitted after reset release.
- Simultaneous events: when the output beat is consumed and a new input is accepted in the same cycle, both take effect; no beat is lost or duplicated.
- X-safety: data registers may update when the valid bit is 0, but Out_valid must never go high from a bubble.

Test Plan:
- DATA_WIDTH=8, STAGES=2, Out_ready=1: A=0xFF, B=0x01, Carry_in=0, Sub=0 accepted at cycle 0 -> at cycle 2, Out_valid=1, Sum=0x00, Carry_out=1, Overflow=0.
- Subtract, 8/2: A=0x80, B=0x01, Carry_in=0, Sub=1 -> Sum=0x7F, Carry_out=1, Overflow=1. Then A=0x00, B=0x01 -> Sum=0xFF, Carry_out=0, Overflow=0.
- Streaming, 32/4: 8 consecutive beats A=i, B=0xFFFF_FFFF, Carry_in=1 (i=0..7) -> 8 consecutive results Sum=i, Carry_out=1 on cycles 4..11, no bubbles.
- Back-pressure, 32/4: drop Out_ready for 3 cycles while Out_valid=1 -> Sum is held stable, In_ready=0 during the stall. After release, results arrive in order with none lost or duplicated.
- Reset mid-flight: assert RST_n=0 asynchronously, between clock edges, with 3 beats in flight -> outputs are 0 immediately. After release, Out_valid stays 0 until a new beat has been accepted and STAGES cycles have elapsed.
- Random: 10k random A/B/Carry_in/Sub with random In_valid/Out_ready, DATA_WIDTH in {8,32,64}, STAGES in {1,2,4,8} -> all outputs match the reference model in order.
